// File: rtl/hd_data_loader_if.sv
// Stream, control, memory-write and status signals between the host side and
// the projection/feature loader.
interface hd_data_loader_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int PROJ_ADDR_WIDTH = 8,
    parameter int FEA_ADDR_WIDTH  = 8
);
    logic                       start;
    logic                       fea_only;
    logic                       abort;
    logic                       in_valid;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       in_ready;
    logic                       proj_we;
    logic [PROJ_ADDR_WIDTH-1:0] proj_waddr;
    logic [DATA_WIDTH-1:0]      proj_wdata;
    logic                       fea_we;
    logic [FEA_ADDR_WIDTH-1:0]  fea_waddr;
    logic [DATA_WIDTH-1:0]      fea_wdata;
    logic                       write_data_done;
    logic                       proj_loaded;
    logic                       busy;

    modport master (
        output start, fea_only, abort, in_valid, in_data,
        input  in_ready, proj_we, proj_waddr, proj_wdata,
        input  fea_we, fea_waddr, fea_wdata,
        input  write_data_done, proj_loaded, busy
    );

    modport slave (
        input  start, fea_only, abort, in_valid, in_data,
        output in_ready, proj_we, proj_waddr, proj_wdata,
        output fea_we, fea_waddr, fea_wdata,
        output write_data_done, proj_loaded, busy
    );
endinterface

// File: rtl/hd_data_loader.sv
// Fills the projection memory then the feature memory from one word stream.
// state     | meaning
// IDLE      | nothing loaded or load cancelled
// LOAD_PROJ | accepting projection words
// LOAD_FEA  | accepting feature words
// FLUSH     | final feature write in flight
// DONE      | both memories valid, write_data_done high
module hd_data_loader #(
    parameter int DATA_WIDTH      = 16,
    parameter int PROJ_WORDS      = 250,
    parameter int FEA_WORDS       = 32,
    parameter int PROJ_ADDR_WIDTH = 8,
    parameter int FEA_ADDR_WIDTH  = 8
) (
    input  logic clk,
    input  logic reset_n,
    hd_data_loader_if.slave bus
);
    localparam logic [PROJ_ADDR_WIDTH-1:0] PROJ_LAST = PROJ_ADDR_WIDTH'(PROJ_WORDS - 1);
    localparam logic [FEA_ADDR_WIDTH-1:0]  FEA_LAST  = FEA_ADDR_WIDTH'(FEA_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD_PROJ, LOAD_FEA, FLUSH, DONE} state_t;

    state_t                     state, state_next;
    logic [PROJ_ADDR_WIDTH-1:0] proj_cnt, proj_waddr_q;
    logic [FEA_ADDR_WIDTH-1:0]  fea_cnt, fea_waddr_q;
    logic [DATA_WIDTH-1:0]      proj_wdata_q, fea_wdata_q;
    logic                       proj_we_q, fea_we_q, done_q, proj_loaded_q;
    logic                       accept, accept_proj, accept_fea, idle_or_done, start_load;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign bus.in_ready = (state == LOAD_PROJ) || (state == LOAD_FEA);
    // abort outranks a word offered on the same edge
    assign accept       = bus.in_valid && bus.in_ready && !bus.abort;
    assign accept_proj  = accept && (state == LOAD_PROJ);
    assign accept_fea   = accept && (state == LOAD_FEA);
    assign start_load   = bus.start && !bus.abort && idle_or_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start)
                    state_next = (bus.fea_only && proj_loaded_q) ? LOAD_FEA : LOAD_PROJ;
                LOAD_PROJ:  if (accept_proj && proj_cnt == PROJ_LAST) state_next = LOAD_FEA;
                LOAD_FEA:   if (accept_fea && fea_cnt == FEA_LAST) state_next = FLUSH;
                FLUSH:      state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proj_cnt      <= '0;
            fea_cnt       <= '0;
            proj_we_q     <= 1'b0;
            proj_waddr_q  <= '0;
            proj_wdata_q  <= '0;
            fea_we_q      <= 1'b0;
            fea_waddr_q   <= '0;
            fea_wdata_q   <= '0;
            done_q        <= 1'b0;
            proj_loaded_q <= 1'b0;
        end else begin
            proj_we_q <= accept_proj;
            fea_we_q  <= accept_fea;
            if (accept_proj) begin
                proj_waddr_q <= proj_cnt;
                proj_wdata_q <= bus.in_data;
            end
            if (accept_fea) begin
                fea_waddr_q <= fea_cnt;
                fea_wdata_q <= bus.in_data;
            end
            // counters return to 0 at the last word so each phase starts clean
            if (bus.abort || start_load) begin
                proj_cnt <= '0;
                fea_cnt  <= '0;
            end else begin
                if (accept_proj) proj_cnt <= (proj_cnt == PROJ_LAST) ? '0 : proj_cnt + 1'b1;
                if (accept_fea)  fea_cnt  <= (fea_cnt == FEA_LAST) ? '0 : fea_cnt + 1'b1;
            end
            if (bus.abort) begin
                if (state == LOAD_PROJ) proj_loaded_q <= 1'b0;
            end else if (start_load && !(bus.fea_only && proj_loaded_q)) begin
                proj_loaded_q <= 1'b0;
            end else if (accept_proj && proj_cnt == PROJ_LAST) begin
                proj_loaded_q <= 1'b1;
            end
            done_q <= (state_next == DONE);
        end
    end

    assign bus.proj_we         = proj_we_q;
    assign bus.proj_waddr      = proj_waddr_q;
    assign bus.proj_wdata      = proj_wdata_q;
    assign bus.fea_we          = fea_we_q;
    assign bus.fea_waddr       = fea_waddr_q;
    assign bus.fea_wdata       = fea_wdata_q;
    assign bus.write_data_done = done_q;
    assign bus.proj_loaded     = proj_loaded_q;
    assign bus.busy            = !idle_or_done;
endmodule
